// File: rtl/accumulator_weight_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlut_acc_pkg
// Description : Shared types and helpers for the accumulator weight bank.
//               Provides the run FSM state encoding, the signed limits of an
//               accumulator of a given width and a sign-extension helper.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package tlut_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Largest positive value of a w-bit signed accumulator: 2^(w-1)-1.
    function automatic logic [63:0] acc_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative value of a w-bit signed accumulator: -2^(w-1).
    // The low w bits of the 64-bit result are 1000...0.
    function automatic logic [63:0] acc_min(input int unsigned w);
        return ~acc_max(w);
    endfunction

    // Sign-extend the low w bits of x to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] x, input int unsigned w);
        logic [63:0] sh;
        sh = x << (64 - w);
        return $signed(sh) >>> (64 - w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accumulator_weight_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_weight_bank_if
// Description : Data-path handshakes of the accumulator weight bank.
//               in_valid/in_ready/val : input weight beats
//               out_valid/out_ready   : final-sum handshake
//               sum/ovf               : packed accumulators, overflow flags
//               master = producer/consumer side, slave = the bank.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface accumulator_weight_bank_if #(
    parameter int NUM_CH    = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CH*IN_WIDTH-1:0]    val;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_CH*ACC_WIDTH-1:0]   sum;
    logic [NUM_CH-1:0]             ovf;

    modport master (
        output in_valid, val, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, val, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface
`default_nettype wire

// File: rtl/accumulator_weight_bank_acc_lane.sv
`default_nettype none
// ============================================================================
// Module      : acc_lane
// Description : One signed accumulator channel with overflow detection and
//               saturate/wrap selection. Owns its sum and sticky ovf flop.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : zero sum and ovf (run start or abort)
//   en_i      : add val_i to the accumulator this cycle
//   val_i     : signed input weight
//   sum_o     : registered accumulator value
//   ovf_o     : sticky overflow flag
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module acc_lane
    import tlut_acc_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int SATURATE  = 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 clr_i,
    input  wire logic                 en_i,
    input  wire logic [IN_WIDTH-1:0]  val_i,
    output logic      [ACC_WIDTH-1:0] sum_o,
    output logic                      ovf_o
);
    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic [ACC_WIDTH-1:0] sum_q;
    logic                 ovf_q;
    logic [ACC_WIDTH-1:0] w_addend;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_next;

    assign w_addend  = ACC_WIDTH'(sext(64'(val_i), IN_WIDTH));
    // One guard bit: the two top bits disagree exactly on signed overflow.
    assign w_sum_ext = {sum_q[ACC_WIDTH-1], sum_q} + {w_addend[ACC_WIDTH-1], w_addend};
    assign w_ovf     = w_sum_ext[ACC_WIDTH] ^ w_sum_ext[ACC_WIDTH-1];

    generate
        if (SATURATE != 0) begin : g_sat
            // The guard bit holds the true sign of the result.
            assign w_next = w_ovf ? (w_sum_ext[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX)
                                  : w_sum_ext[ACC_WIDTH-1:0];
        end else begin : g_wrap
            assign w_next = w_sum_ext[ACC_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            sum_q <= w_next;
            ovf_q <= ovf_q | w_ovf;
        end
    end

    assign sum_o = sum_q;
    assign ovf_o = ovf_q;
endmodule
`default_nettype wire

// File: rtl/accumulator_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_weight_bank
// Description : NUM_CH signed accumulators summing a programmed number of
//               weight beats per run, with per-channel enable mask,
//               saturate/wrap arithmetic and sticky overflow flags.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous abort back to IDLE, zeroes sums/ovf/counter
//   start     : run start pulse (IDLE only, ignored when len_i == 0)
//   len_i     : beats per run, latched on accepted start
//   ch_mask   : per-channel enable, latched on accepted start
//   busy      : block is not IDLE
//   bus       : beat input, sum output handshakes, sum and ovf
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module accumulator_weight_bank
    import tlut_acc_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8,
    parameter int SATURATE  = 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 clear,
    input  wire logic                 start,
    input  wire logic [CNT_WIDTH-1:0] len_i,
    input  wire logic [NUM_CH-1:0]    ch_mask,
    output logic                      busy,
    accumulator_weight_bank_if.slave  bus
);
    state_t                  state_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    len_q;
    logic [NUM_CH-1:0]       mask_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic                    w_beat;
    logic                    w_start_ok;
    logic                    w_last;
    logic                    w_lane_clr;
    logic [NUM_CH*ACC_WIDTH-1:0] w_sum;
    logic [NUM_CH-1:0]       w_ovf;

    // in_ready_q is only high in ACCUM, so this also gates by state.
    assign w_beat     = bus.in_valid & in_ready_q;
    assign w_start_ok = start & (state_q == ST_IDLE) & (len_i != '0);
    assign w_last     = w_beat & (cnt_q == (len_q - CNT_WIDTH'(1)));
    // Lanes zero on an accepted start or an abort; clear outranks a beat
    // because the lane checks clr_i before en_i.
    assign w_lane_clr = clear | w_start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            mask_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        state_q    <= ST_ACCUM;
                        cnt_q      <= '0;
                        len_q      <= len_i;
                        mask_q     <= ch_mask;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (w_beat) begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (w_last) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
            acc_lane #(
                .IN_WIDTH  (IN_WIDTH),
                .ACC_WIDTH (ACC_WIDTH),
                .SATURATE  (SATURATE)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .clr_i (w_lane_clr),
                .en_i  (w_beat & mask_q[g]),
                .val_i (bus.val[g*IN_WIDTH +: IN_WIDTH]),
                .sum_o (w_sum[g*ACC_WIDTH +: ACC_WIDTH]),
                .ovf_o (w_ovf[g])
            );
        end
    endgenerate

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = w_sum;
    assign bus.ovf       = w_ovf;
    assign busy          = busy_q;
endmodule
`default_nettype wire

// File: doc/accumulator_weight_bank.md
Name: accumulator_weight_bank

Overview:
- Parametrised successor to the single-mode weight accumulator bank in the MatMul_tlut datapath.
- Holds NUM_CH signed accumulators. Accepts weight beats on a valid/ready handshake and accumulates a run-time programmed number of beats (a "run").
- Presents the final sums on a valid/ready output handshake.
- Adds over the previous generation: a per-channel enable mask, a selectable saturate/wrap mode, sticky per-channel overflow flags, and a run-length FSM.

Parameters:
- NUM_CH, 4, number of accumulator channels
- IN_WIDTH, 8, signed input weight width
- ACC_WIDTH, 24, signed accumulator width (must be > IN_WIDTH)
- CNT_WIDTH, 8, width of the run-length counter and len_i
- SATURATE, 1, 1 = clamp on signed overflow, 0 = two's-complement wrap

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-high
- clear  input  1  synchronous abort, highest priority after rst
- start  input  1  run start pulse, honoured only in IDLE
- len_i  input  CNT_WIDTH  beats per run, sampled on accepted start
- ch_mask  input  NUM_CH  per-channel enable, sampled on accepted start
- in_valid  input  1  input beat valid
- in_ready  output  1  bank can take a beat
- val  input  NUM_CH*IN_WIDTH  packed signed weights, channel i at [i*IN_WIDTH +: IN_WIDTH]
- out_valid  output  1  final sums available
- out_ready  input  1  consumer accepts sums
- sum  output  NUM_CH*ACC_WIDTH  packed signed accumulator values
- ovf  output  NUM_CH  sticky per-channel overflow flags for the current run
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1, async):
  - state=IDLE; all sum lanes=0, ovf=0, counter=0, latched len=0, latched mask=0.
  - in_ready=0, out_valid=0, busy=0.
  - Deasserting rst mid-run returns the block to IDLE with no residual state.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 and len_i!=0 -> ACCUM next cycle; sums and ovf zeroed; counter=0; len_i and ch_mask latched.
  - start with len_i==0 is ignored; the block stays in IDLE and sums keep their previous values.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid&in_ready.
  - Per accepted beat, each lane with its mask bit set does sum[i] <= sum[i] + sext(val[i]) to ACC_WIDTH. Masked lanes hold their value.
  - Counter increments on every accepted beat.
  - An accepted beat with counter==len-1 -> HOLD. The final sums are visible on the next cycle, so latency from the last accepted beat to out_valid is 1 cycle.
- HOLD:
  - in_ready=0, out_valid=1; sum and ovf are stable.
  - out_ready=1 -> IDLE next cycle. sum and ovf keep their values until the next accepted start or clear.
- Arithmetic, per lane:
  - Compute an (ACC_WIDTH+1)-bit signed sum and detect signed overflow.
  - SATURATE=1: clamp to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1).
  - SATURATE=0: keep the wrapped low ACC_WIDTH bits.
  - In both modes ovf[i] sets on overflow and stays set until the next start or clear.
- clear=1:
  - Next cycle state=IDLE and all sums, ovf and the counter are 0, regardless of state.
  - clear beats start, an accepted beat, and an out handshake occurring in the same cycle.
- start outside IDLE is ignored.
- in_valid outside ACCUM is ignored (in_ready=0).
- sum is a direct register output, with no combinational path from val.

Decomposition:
- Package tlut_acc_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - localparams for ACC_MAX and ACC_MIN derived from ACC_WIDTH;
  - a sign-extend function.
- One sub-module, acc_lane: a single-channel adder with overflow detect and saturate/wrap select, instantiated NUM_CH times in a generate loop. The top level owns the FSM, counter and handshakes.

Test Plan:
- Basic run: len_i=3, mask=4'b1111, beats ch0={5,-2,7}, back-to-back -> out_valid one cycle after the 3rd beat; sum[0]=10; ovf=0; in_ready=0 during HOLD.
- Mask: len_i=2, mask=4'b0101, all channels fed {3,3} -> sum[0]=sum[2]=6, sum[1]=sum[3]=0.
- Saturate: SATURATE=1, ACC_WIDTH=10, IN_WIDTH=8, len_i=8, ch0 fed 127 each beat -> sum[0]=511, ovf[0]=1. Repeat with SATURATE=0 -> sum[0]=-8 (1016 wrapped), ovf[0]=1.
- Backpressure: in_valid gaps and out_ready held low 5 cycles in HOLD -> sum stable, out_valid high throughout; IDLE the cycle after out_ready=1.
- Clear/start priority: clear and start asserted together in IDLE -> stays IDLE. clear mid-ACCUM after 2 of 4 beats -> IDLE, sums 0, the following start works normally.
- Async reset: rst pulsed mid-clock in HOLD -> immediate out_valid=0, sum=0. start with len_i=0 -> no state change.
